// File: rtl/nn_fixed_pkg.sv
// Shared Q8.24 fixed-point constants, lane type and saturating narrow helper.
package nn_fixed_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned FRAC  = 24;

    localparam logic [31:0] Q_ONE = 32'h0100_0000;
    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;

    typedef logic signed [31:0] q824_t;

    // Clamp a wide signed value into a signed field of the given width.
    function automatic q824_t sat_narrow(input logic signed [63:0] full,
                                         input int unsigned       width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (full > hi) begin
            return q824_t'(hi[31:0]);
        end else if (full < lo) begin
            return q824_t'(lo[31:0]);
        end
        return q824_t'(full[31:0]);
    endfunction

endpackage

// File: rtl/reduce_add_stage.sv
// One registered level of the adder tree: sums adjacent pairs with one bit of growth.
module reduce_add_stage #(
    parameter int unsigned N_IN = 2,
    parameter int unsigned IN_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            valid_in,
    input  logic [N_IN*IN_W-1:0]            data_in,
    output logic [(N_IN/2)*(IN_W+1)-1:0]    data_out,
    output logic                            valid_out
);

    localparam int unsigned N_OUT = N_IN / 2;
    localparam int unsigned OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] sum_d;
    logic [N_OUT*OUT_W-1:0] sum_q;
    logic                   valid_q;
    logic [IN_W-1:0]        a;
    logic [IN_W-1:0]        b;

    // Sign-extend both operands by one bit so the pair sum is exact.
    always_comb begin
        sum_d = '0;
        a     = '0;
        b     = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            a = data_in[(2*j)*IN_W +: IN_W];
            b = data_in[(2*j+1)*IN_W +: IN_W];
            sum_d[j*OUT_W +: OUT_W] = {a[IN_W-1], a} + {b[IN_W-1], b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (en) begin
            valid_q <= valid_in;
        end
    end

    // Data needs no reset: it is qualified by valid_q everywhere downstream.
    always_ff @(posedge clk) begin
        if (en) begin
            sum_q <= sum_d;
        end
    end

    assign data_out  = sum_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/vec_reduce_sum32.sv
// Pipelined signed lane-sum reduction with a global-stall valid/ready pipe.
// REDUCE_SAT_EN: when defined, out_sum saturates on overflow instead of wrapping.
module vec_reduce_sum32
    import nn_fixed_pkg::*;
#(
    parameter int unsigned LANES = 32,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] in_vec,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_ovf
);

    localparam int unsigned STAGES = $clog2(LANES);
    localparam int unsigned FULL_W = WIDTH + STAGES;

    if (LANES < 2 || (LANES & (LANES - 1)) != 0 || FRAC >= WIDTH) begin : g_bad_cfg
        $error("vec_reduce_sum32: LANES must be a power of two >= 2 and FRAC < WIDTH");
    end

    logic              adv;
    logic [FULL_W-1:0] full_sum;
    logic              full_vld;
    logic              ovf_c;
    logic [WIDTH-1:0]  narrow_c;
    logic [WIDTH-1:0]  out_sum_q;
    logic              out_valid_q;
    logic              out_ovf_q;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned N_IN = LANES >> k;
        localparam int unsigned IN_W = WIDTH + k;

        logic [(N_IN/2)*(IN_W+1)-1:0] stage_sum;
        logic                         stage_vld;

        if (k == 0) begin : g_first
            reduce_add_stage #(.N_IN(N_IN), .IN_W(IN_W)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (adv),
                .valid_in  (in_valid),
                .data_in   (in_vec),
                .data_out  (stage_sum),
                .valid_out (stage_vld)
            );
        end else begin : g_rest
            reduce_add_stage #(.N_IN(N_IN), .IN_W(IN_W)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (adv),
                .valid_in  (g_stage[k-1].stage_vld),
                .data_in   (g_stage[k-1].stage_sum),
                .data_out  (stage_sum),
                .valid_out (stage_vld)
            );
        end
    end

    assign full_sum = g_stage[STAGES-1].stage_sum;
    assign full_vld = g_stage[STAGES-1].stage_vld;

    // In range iff all bits from the WIDTH-1 sign position upward agree.
    assign ovf_c = !((&full_sum[FULL_W-1:WIDTH-1]) || !(|full_sum[FULL_W-1:WIDTH-1]));

`ifdef REDUCE_SAT_EN
    assign narrow_c = WIDTH'(sat_narrow(64'($signed(full_sum)), WIDTH));
`else
    assign narrow_c = full_sum[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= full_vld;
            out_sum_q   <= narrow_c;
            out_ovf_q   <= full_vld && ovf_c;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_valid = out_valid_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vec_reduce_sum32.sv
// Directed scoreboard bench for vec_reduce_sum32 (wrap or saturating build).
module tb_vec_reduce_sum32;

    localparam int unsigned LANES = 32;
    localparam int unsigned WIDTH = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [LANES*WIDTH-1:0] in_vec;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       out_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_ovf;

    vec_reduce_sum32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          pops  = 0;
    int          last_push_cyc = 0;
    int          last_pop_cyc  = 0;
    logic [31:0] last_sum = '0;
    logic        last_ovf = 1'b0;
    logic        in_hist  [4096];
    logic        out_hist [4096];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [LANES*WIDTH-1:0] v);
        exp_t        e;
        longint      s;
        logic [31:0] lane;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            lane = v[i*WIDTH +: WIDTH];
            s += longint'($signed(lane));
        end
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef REDUCE_SAT_EN
        if (s > 64'sd2147483647)       e.sum = 32'h7FFF_FFFF;
        else if (s < -64'sd2147483648) e.sum = 32'h8000_0000;
        else                           e.sum = s[31:0];
`else
        e.sum = s[31:0];
`endif
        return e;
    endfunction

    function automatic logic [LANES*WIDTH-1:0] mk_all(input logic [31:0] x);
        return {LANES{x}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pushes on input transfer, pops and compares on output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (cyc < 4096) begin
                in_hist[cyc]  = in_valid && in_ready;
                out_hist[cyc] = out_valid;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(out_sum), 64'hDEAD);
                end else begin
                    e = sb.pop_front();
                    check("sb_sum", 64'(out_sum), 64'(e.sum));
                    check("sb_ovf", 64'(out_ovf), 64'(e.ovf));
                end
                pops++;
                last_pop_cyc = cyc;
                last_sum     = out_sum;
                last_ovf     = out_ovf;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_vec));
                last_push_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_one(input logic [LANES*WIDTH-1:0] v);
        step();
        in_vec   = v;
        in_valid = 1'b1;
        @(negedge clk);
        check("send_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 100);
        if (n >= 100) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [LANES*WIDTH-1:0] v;
        logic [31:0]            held;
        int                     idx;
        int                     i;
        int                     p0;
        int                     c [5];
        logic                   pat [5];

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_vec    = '0;
        held      = '0;
        pat       = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;

        // Ones: 32 x 1.0 = 32.0, six-cycle latency.
        send_one(mk_all(32'h0100_0000));
        drain();
        check("ones_sum", 64'(last_sum), 64'h2000_0000);
        check("ones_ovf", 64'(last_ovf), 64'd0);
        check("ones_latency", 64'(last_pop_cyc - last_push_cyc), 64'd6);

        // Cancellation across lane 0 (MSB slice) and lane 31 (LSB slice).
        v = '0;
        v[LANES*WIDTH-1 -: WIDTH] = 32'h0200_0000;
        v[WIDTH-1:0]              = 32'hFE00_0000;
        send_one(v);
        drain();
        check("cancel_sum", 64'(last_sum), 64'h0);
        check("cancel_ovf", 64'(last_ovf), 64'd0);

        // Mixed-sign non-trivial vector handled entirely by the model.
        for (int k = 0; k < LANES; k++) begin
            v[k*WIDTH +: WIDTH] = (k % 3 == 0) ? 32'(-(k * 32'h0003_1000)) : 32'(k * 32'h0012_3400);
        end
        send_one(v);
        drain();

        // Positive overflow.
        send_one(mk_all(32'h7FFF_FFFF));
        drain();
        check("povf_ovf", 64'(last_ovf), 64'd1);
`ifdef REDUCE_SAT_EN
        check("povf_sum", 64'(last_sum), 64'h7FFF_FFFF);
`else
        check("povf_sum", 64'(last_sum), 64'hFFFF_FFE0);
`endif

        // Negative overflow.
        send_one(mk_all(32'h8000_0000));
        drain();
        check("novf_ovf", 64'(last_ovf), 64'd1);
`ifdef REDUCE_SAT_EN
        check("novf_sum", 64'(last_sum), 64'h8000_0000);
`else
        check("novf_sum", 64'(last_sum), 64'h0);
`endif

        // Backpressure: stream 1.0..10.0, stall output on cycles 8-10.
        p0  = pops;
        idx = 0;
        i   = 0;
        while (idx < 10 && i < 60) begin
            i++;
            step();
            out_ready = !(i >= 8 && i <= 10);
            in_valid  = 1'b1;
            in_vec    = mk_all(32'(idx + 1) << 19);
            @(negedge clk);
            if (i >= 8 && i <= 10) begin
                check("bp_in_ready",  64'(in_ready),  64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                if (i == 8) held = out_sum;
                else check("bp_sum_stable", 64'(out_sum), 64'(held));
            end
            if (in_ready) idx++;
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        check("bp_count", 64'(pops - p0), 64'd10);
        check("bp_last_sum", 64'(last_sum), 64'h0A00_0000);

        // Bubbles: out_valid mirrors in_valid six cycles later.
        p0 = pops;
        for (int k = 0; k < 5; k++) begin
            step();
            in_valid = pat[k];
            in_vec   = mk_all(32'(k + 1) << 20);
            @(negedge clk);
            c[k] = cyc;
        end
        step();
        in_valid = 1'b0;
        drain();
        for (int k = 0; k < 5; k++) begin
            check("bubble_out_valid", 64'(out_hist[c[k] + 6]), 64'(pat[k]));
        end
        check("bubble_count", 64'(pops - p0), 64'd3);

        // Reset with three vectors in flight.
        for (int k = 0; k < 3; k++) begin
            step();
            in_valid = 1'b1;
            in_vec   = mk_all(32'h0100_0000 + 32'(k));
        end
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum",   64'(out_sum),   64'd0);
        p0 = pops;
        repeat (12) @(negedge clk);
        check("midrst_no_result", 64'(pops - p0), 64'd0);
        check("midrst_sb_empty",  64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_reduce_sum32.md
Name: vec_reduce_sum32

Overview:
- Pipelined lane-sum reduction stage placed directly downstream of the 32-lane Hadamard multiplier.
- Consumes one packed 1024-bit vector of 32 signed Q8.24 lanes per transfer and produces their scalar sum in Q8.24.
- Used to finish a dot product (neuron pre-activation = sum of weight x input).
- Valid/ready handshake on both sides; registered binary adder tree.

Parameters:
- LANES, 32, number of lanes; must be a power of two, >= 2.
- WIDTH, 32, lane width in bits, signed two's complement.
- FRAC, 24, fractional bits; carried through unchanged, no rescaling.
- STAGES, $clog2(LANES) = 5, adder-tree depth; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_vec  in  LANES*WIDTH  packed lanes; lane 0 at [LANES*WIDTH-1 -: WIDTH], lane LANES-1 at [WIDTH-1:0] (upstream packing)
- in_valid  in  1  in_vec valid
- in_ready  out  1  stage can accept this cycle
- out_sum  out  WIDTH  Q8.24 sum of all lanes
- out_valid  out  1  out_sum valid
- out_ready  in  1  downstream accepts out_sum
- out_ovf  out  1  sum exceeded signed WIDTH range (sticky per result, not across results)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_sum=0, out_ovf=0, all internal stage-valid bits 0. Reset clears data in flight; no stale result may emerge after reset.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). All stages shift only when adv=1; otherwise every stage holds, bubbles included.
- Stage 1: sign-extend each lane to WIDTH+1 and add adjacent pairs (0+1, 2+3, …). Register LANES/2 partials plus valid.
- Stage k: partial width WIDTH+k, pairwise add; stage STAGES holds one WIDTH+STAGES (37-bit) sum.
- Output register: loaded from stage STAGES on adv.
  - out_ovf = 1 iff the full-width sum is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - out_sum per Optional Feature.
- Latency: STAGES+1 = 6 cycles from input transfer to out_valid, with no backpressure. Throughput 1 vector/cycle.
- Valid bit of each stage = previous stage valid on adv. Bubbles (in_valid=0) propagate as invalid entries.
- Backpressure: while out_valid && !out_ready, in_ready=0, the whole pipe freezes, and out_sum/out_ovf stay stable. No data loss, no duplication, order preserved.
- Simultaneous out transfer and new arrival at the output register in the same cycle is legal; the new result replaces the old with no gap.
- in_vec is sampled only on input transfer; changes while in_ready=0 are ignored.
- Arithmetic is exact inside the tree (no intermediate overflow). Only the final narrowing to WIDTH can lose range.

Optional Feature:
- Macro: REDUCE_SAT_EN.
- Defined: out_sum saturates to 0x7FFFFFFF on positive overflow and to 0x80000000 on negative overflow.
- Undefined: out_sum = low WIDTH bits of the full sum (wrap).
- out_ovf behaves identically in both builds.

Decomposition:
- Shared package nn_fixed_pkg:
  - Q8.24 constants: WIDTH=32, FRAC=24, Q_ONE=32'h01000000, Q_MAX=32'h7FFFFFFF, Q_MIN=32'h80000000.
  - typedef q824_t (signed [31:0]).
  - Saturating-narrow function sat_narrow(full, width).
- One natural sub-module: reduce_add_stage. One registered level with parameters N_IN and IN_W, inputs en and valid_in, outputs N_IN/2 sums at width IN_W+1. Instantiated STAGES times via generate.

Test Plan:
- Ones: all 32 lanes = 0x01000000, single transfer -> out_sum=0x20000000 (32.0), out_ovf=0, out_valid rises exactly 6 cycles after the input transfer.
- Cancellation: lane0=0x02000000, lane31=0xFE000000, others 0 -> out_sum=0x00000000, out_ovf=0. Also verifies packing order and sign extension.
- Overflow: all lanes = 0x7FFFFFFF -> out_ovf=1.
  - With REDUCE_SAT_EN: out_sum=0x7FFFFFFF.
  - Without: out_sum=0xFFFFFFE0.
  - All lanes = 0x80000000 with REDUCE_SAT_EN -> out_sum=0x80000000, out_ovf=1.
- Backpressure: stream vectors with sums 1.0..10.0 back to back; hold out_ready=0 for cycles 8-10 -> in_ready=0 over the same cycles, out_sum stable, all 10 results delivered in order, none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,0,1 -> three results, out_valid pattern mirrors the input pattern delayed by 6 cycles.
- Reset mid-flight: 3 vectors in flight, assert rst for 1 cycle -> out_valid=0 and out_sum=0 the next cycle, and no result ever appears for those vectors.
